// File: rtl/i2c_decoder_pkg.sv
// Shared event types for the passive I2C bus decoder and its event FIFO.
`default_nettype none

package i2c_decoder_pkg;

  typedef enum logic [1:0] {
    START  = 2'd0,
    RSTART = 2'd1,
    STOP   = 2'd2,
    BYTE   = 2'd3
  } i2c_evt_type_t;

  typedef struct packed {
    i2c_evt_type_t evt_type;
    logic [7:0]    data;
    logic          ack;
    logic          err;
  } i2c_evt_t;

  typedef enum logic {
    IDLE = 1'b0,
    DATA = 1'b1
  } i2c_state_t;

  localparam int CNT_W = 4;

endpackage

`default_nettype wire

// File: rtl/i2c_evt_fifo.sv
// Synchronous FIFO of decoded I2C events; head is read straight from storage registers.
`default_nettype none

module i2c_evt_fifo
  import i2c_decoder_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     push,
  input  i2c_evt_t push_data,
  input  logic     pop,
  output i2c_evt_t head,
  output logic     full,
  output logic     empty
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic [AW:0] wptr;
  logic [AW:0] rptr;
  i2c_evt_t    mem [FIFO_DEPTH];
  logic        do_push;
  logic        do_pop;

  assign empty = (wptr == rptr);
  assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot, so a push into a full FIFO is still taken.
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr[AW-1:0]] <= push_data;
  end

endmodule

`default_nettype wire

// File: rtl/i2c_bus_decoder.sv
// Passive I2C observer: synchronize and filter SCL/SDA, decode START/RSTART/STOP/BYTE
// events and queue them on a valid/ready stream.
`default_nettype none

module i2c_bus_decoder
  import i2c_decoder_pkg::*;
#(
  parameter int FILTER_LEN = 3,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       evt_valid_o,
  input  logic       evt_ready_i,
  output logic [1:0] evt_type_o,
  output logic [7:0] evt_data_o,
  output logic       evt_ack_o,
  output logic       evt_err_o,
  output logic       bus_busy_o,
  output logic       overflow_o,
  input  logic       clr_ovf_i
);

  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(FILTER_LEN - 1);

  logic [1:0] raw_line;
  logic [1:0] filt;
  logic [1:0] filt_d;

  assign raw_line = {sda_i, scl_i};

  for (genvar i = 0; i < 2; i++) begin : g_line
    logic             s1;
    logic             s2;
    logic             f;
    logic             fd;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk_i) begin
      if (!rst_i) begin
        s1  <= 1'b1;
        s2  <= 1'b1;
        f   <= 1'b1;
        fd  <= 1'b1;
        cnt <= RELOAD;
      end else begin
        s1 <= raw_line[i];
        s2 <= s1;
        fd <= f;
        if (s2 == f) begin
          cnt <= RELOAD;
        end else if (cnt == '0) begin
          f   <= s2;
          cnt <= RELOAD;
        end else begin
          cnt <= cnt - 4'd1;
        end
      end
    end

    assign filt[i]   = f;
    assign filt_d[i] = fd;
  end

  logic scl;
  logic sda;
  logic scl_rise;
  logic scl_steady_hi;
  logic start_cond;
  logic stop_cond;

  assign scl           = filt[0];
  assign sda           = filt[1];
  assign scl_rise      = scl & ~filt_d[0];
  assign scl_steady_hi = scl & filt_d[0];
  assign start_cond    = ~sda & filt_d[1] & scl_steady_hi;
  assign stop_cond     = sda & ~filt_d[1] & scl_steady_hi;

  i2c_state_t state;
  i2c_state_t state_nxt;
  logic [3:0] bit_cnt;
  logic [3:0] bit_cnt_nxt;
  logic [7:0] shreg;
  logic [7:0] shreg_nxt;
  logic       push_q;
  logic       push_nxt;
  i2c_evt_t   evt_q;
  i2c_evt_t   evt_nxt;
  logic       partial;

  // The SCL rise that sets up a STOP/RSTART has already counted one bit; only more than that is a cut byte.
  assign partial = (bit_cnt > 4'd1);

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state   <= IDLE;
      bit_cnt <= '0;
      shreg   <= '0;
      push_q  <= 1'b0;
      evt_q   <= '0;
    end else begin
      state   <= state_nxt;
      bit_cnt <= bit_cnt_nxt;
      shreg   <= shreg_nxt;
      push_q  <= push_nxt;
      evt_q   <= evt_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    bit_cnt_nxt = bit_cnt;
    shreg_nxt   = shreg;
    push_nxt    = 1'b0;
    evt_nxt     = '0;
    unique case (state)
      IDLE: begin
        if (start_cond) begin
          push_nxt         = 1'b1;
          evt_nxt.evt_type = START;
          state_nxt        = DATA;
          bit_cnt_nxt      = '0;
        end
      end
      DATA: begin
        if (start_cond) begin
          push_nxt         = 1'b1;
          evt_nxt.evt_type = RSTART;
          evt_nxt.err      = partial;
          bit_cnt_nxt      = '0;
        end else if (stop_cond) begin
          push_nxt         = 1'b1;
          evt_nxt.evt_type = STOP;
          evt_nxt.err      = partial;
          state_nxt        = IDLE;
          bit_cnt_nxt      = '0;
        end else if (scl_rise) begin
          if (bit_cnt == 4'd8) begin
            push_nxt         = 1'b1;
            evt_nxt.evt_type = BYTE;
            evt_nxt.data     = shreg;
            evt_nxt.ack      = sda;
            bit_cnt_nxt      = '0;
          end else begin
            shreg_nxt   = {shreg[6:0], sda};
            bit_cnt_nxt = bit_cnt + 4'd1;
          end
        end
      end
    endcase
  end

  i2c_evt_t head;
  logic     fifo_full;
  logic     fifo_empty;

  i2c_evt_fifo #(
    .FIFO_DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk_i),
    .rst_n    (rst_i),
    .push     (push_q),
    .push_data(evt_q),
    .pop      (evt_ready_i),
    .head     (head),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      overflow_o <= 1'b0;
    end else if (push_q && fifo_full && !evt_ready_i) begin
      overflow_o <= 1'b1;
    end else if (clr_ovf_i) begin
      overflow_o <= 1'b0;
    end
  end

  // Storage is not reset, so the head fields are masked whenever the FIFO is empty.
  assign evt_valid_o = !fifo_empty;
  assign evt_type_o  = evt_valid_o ? head.evt_type : 2'b00;
  assign evt_data_o  = evt_valid_o ? head.data : 8'h00;
  assign evt_ack_o   = evt_valid_o & head.ack;
  assign evt_err_o   = evt_valid_o & head.err;
  assign bus_busy_o  = (state == DATA);

endmodule

`default_nettype wire

// File: tb/tb_i2c_bus_decoder.sv
// Directed and randomized bus traffic against a transaction-level event model.
`default_nettype none

module tb_i2c_bus_decoder;

  localparam int HALF  = 8;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       scl = 1'b1;
  logic       sda = 1'b1;
  logic       ready = 1'b1;
  logic       clr = 1'b0;
  logic       evt_valid;
  logic [1:0] evt_type;
  logic [7:0] evt_data;
  logic       evt_ack;
  logic       evt_err;
  logic       busy;
  logic       ovf;

  i2c_bus_decoder #(.FILTER_LEN(3), .FIFO_DEPTH(DEPTH)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .scl_i      (scl),
    .sda_i      (sda),
    .evt_valid_o(evt_valid),
    .evt_ready_i(ready),
    .evt_type_o (evt_type),
    .evt_data_o (evt_data),
    .evt_ack_o  (evt_ack),
    .evt_err_o  (evt_err),
    .bus_busy_o (busy),
    .overflow_o (ovf),
    .clr_ovf_i  (clr)
  );

  always #5 clk = ~clk;

  int          vectors = 0;
  int          miscompares = 0;
  logic [11:0] exp_q[$];
  logic [11:0] got_q[$];
  int          bits_m = 0;
  logic        busy_m = 1'b0;
  logic [7:0]  sr_m = 8'h00;
  bit          stalled = 1'b0;
  int          stall_m = 0;
  int          lat = -1;

  always @(negedge clk) begin
    if (rst && evt_valid && ready) got_q.push_back({evt_type, evt_data, evt_ack, evt_err});
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected events; while the consumer stalls only DEPTH of them can be held.
  task automatic model_evt(input logic [1:0] t, input logic [7:0] d, input logic a, input logic e);
    if (stalled) begin
      if (stall_m >= DEPTH) return;
      stall_m++;
    end
    exp_q.push_back({t, d, a, e});
  endtask

  task automatic phase();
    repeat (HALF) @(posedge clk);
    #1;
  endtask

  task automatic t_start();
    sda = 1'b1; phase();
    scl = 1'b1; phase();
    @(posedge clk); #1;
    sda = 1'b0;
    lat = -1;
    for (int i = 1; i <= HALF + 4; i++) begin
      @(posedge clk); #1;
      if (evt_valid && lat < 0) lat = i;
    end
    scl = 1'b0; phase();
    if (!busy_m) model_evt(2'd0, 8'h00, 1'b0, 1'b0);
    else         model_evt(2'd1, 8'h00, 1'b0, bits_m != 0);
    busy_m = 1'b1;
    bits_m = 0;
  endtask

  task automatic t_bit(input logic b);
    sda = b;    phase();
    scl = 1'b1; phase();
    scl = 1'b0; phase();
    bits_m++;
    if (bits_m == 9) begin
      model_evt(2'd3, sr_m, b, 1'b0);
      bits_m = 0;
    end else begin
      sr_m = {sr_m[6:0], b};
    end
  endtask

  task automatic t_stop();
    sda = 1'b0; phase();
    scl = 1'b1; phase();
    sda = 1'b1; phase();
    model_evt(2'd2, 8'h00, 1'b0, bits_m != 0);
    busy_m = 1'b0;
    bits_m = 0;
  endtask

  task automatic send_byte(input logic [7:0] d, input logic a);
    for (int i = 7; i >= 0; i--) t_bit(d[i]);
    t_bit(a);
  endtask

  task automatic compare_queues(input string tag);
    int n;
    repeat (20) @(posedge clk);
    #1;
    check($sformatf("%s_count", tag), got_q.size(), exp_q.size());
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) check($sformatf("%s_ev%0d", tag, i), got_q[i], exp_q[i]);
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    logic [11:0] head0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_valid", evt_valid, 1'b0);
    check("reset_busy", busy, 1'b0);
    check("reset_ovf", ovf, 1'b0);
    rst = 1'b1;
    repeat (10) @(posedge clk);
    #1;

    // Write 0xA4 with ACK
    t_start();
    check("start_latency", lat, 7);
    check("busy_after_start", busy, 1'b1);
    send_byte(8'hA4, 1'b0);
    check("busy_mid_frame", busy, 1'b1);
    t_stop();
    check("busy_after_stop", busy, 1'b0);
    compare_queues("write_a4");

    // Repeated start
    t_start();
    send_byte(8'h50, 1'b0);
    t_start();
    send_byte(8'h51, 1'b1);
    t_stop();
    compare_queues("rstart");

    // Abort after three bits
    t_start();
    t_bit(1'b1); t_bit(1'b0); t_bit(1'b1);
    t_stop();
    check("abort_busy", busy, 1'b0);
    compare_queues("abort");

    // Two-cycle SDA glitch on an idle bus
    @(posedge clk); #1; sda = 1'b0;
    @(posedge clk); @(posedge clk); #1; sda = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    check("glitch_busy", busy, 1'b0);
    check("glitch_events", got_q.size(), 0);
    compare_queues("glitch");

    // Overflow with a stalled consumer
    ready = 1'b0;
    stalled = 1'b1;
    stall_m = 0;
    t_start();
    for (int i = 0; i < 4; i++) send_byte(8'(8'h10 + i), 1'b0);
    t_stop();
    repeat (20) @(posedge clk);
    #1;
    check("ovf_set", ovf, 1'b1);
    check("ovf_valid", evt_valid, 1'b1);
    head0 = {evt_type, evt_data, evt_ack, evt_err};
    check("ovf_head", head0, exp_q[0]);
    repeat (5) @(posedge clk);
    #1;
    check("ovf_head_stable", {evt_type, evt_data, evt_ack, evt_err}, exp_q[0]);
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    check("ovf_cleared", ovf, 1'b0);
    ready = 1'b1;
    stalled = 1'b0;
    compare_queues("overflow");

    // Reset in the middle of a byte
    t_start();
    t_bit(1'b0); t_bit(1'b0); t_bit(1'b1); t_bit(1'b1); t_bit(1'b1);
    compare_queues("rst_pre");
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    check("rst_mid_valid", evt_valid, 1'b0);
    check("rst_mid_fields", {evt_type, evt_data, evt_ack, evt_err}, 12'h000);
    check("rst_mid_busy", busy, 1'b0);
    check("rst_mid_ovf", ovf, 1'b0);
    busy_m = 1'b0;
    bits_m = 0;
    repeat (10) @(posedge clk);
    #1;
    t_start();
    send_byte(8'h3C, 1'b0);
    t_stop();
    compare_queues("after_rst");

    // Randomized transactions
    for (int t = 0; t < 4; t++) begin
      int nb;
      nb = int'($urandom_range(1, 3));
      t_start();
      for (int j = 0; j < nb; j++) begin
        if (j > 0 && ($urandom_range(0, 2) == 0)) t_start();
        send_byte(8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
      end
      t_stop();
      compare_queues($sformatf("rand%0d", t));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/i2c_bus_decoder.md
Name: i2c_bus_decoder

Overview:
- Synthesizable passive I2C bus observer that sits directly upstream of the I2C monitor.
- Samples raw SCL/SDA from one bus and decodes START, repeated START, STOP and complete byte+ACK frames.
- Delivers decoded events on a valid/ready stream through a small event FIFO.
- The monitor consumes this stream and builds transactions from events, not raw pins.

Parameters:
- FILTER_LEN, 3: consecutive identical synchronized samples required before a filtered line changes (1..15).
- FIFO_DEPTH, 4: event FIFO entries; power of two, 2..16.

Ports:
- clk_i  in  1  system clock.
- rst_i  in  1  reset, synchronous, active-low.
- scl_i  in  1  raw SCL, asynchronous to clk_i.
- sda_i  in  1  raw SDA, asynchronous to clk_i.
- evt_valid_o  out  1  event available at FIFO head.
- evt_ready_i  in  1  consumer accepts head event when evt_valid_o is high.
- evt_type_o  out  2  head event type: START=0, RSTART=1, STOP=2, BYTE=3.
- evt_data_o  out  8  byte value, MSB first on bus; 0 for non-BYTE events.
- evt_ack_o  out  1  sampled 9th bit (0 = ACK, 1 = NACK); 0 for non-BYTE events.
- evt_err_o  out  1  START or STOP arrived mid-byte; partial byte discarded.
- bus_busy_o  out  1  high from START until STOP.
- overflow_o  out  1  sticky; set when an event is dropped because the FIFO is full.
- clr_ovf_i  in  1  clears overflow_o.

Behaviour:
- Reset (rst_i low at a clk_i edge):
  - Sync and filter registers go to 1 (idle bus).
  - FSM goes to IDLE; bit_cnt = 0.
  - FIFO emptied; all outputs 0.
  - Reset mid-frame abandons the frame silently; no event is emitted.
- Input path: 2-FF synchronizer per line, then filter.
  - Filter counter reloads whenever the sync output equals the filtered value.
  - Filtered value flips after FILTER_LEN consecutive cycles of the opposite value.
- Edge detect compares the filtered line with its one-cycle-delayed copy.
- Line events, evaluated on filtered signals:
  - SDA fall while SCL high (and SCL not changing) = start condition.
  - SDA rise while SCL high = stop condition.
  - SDA and SCL changing in the same cycle = data change, no start/stop.
- FSM:
  - IDLE: start condition -> push START; go to DATA; bit_cnt = 0; bus_busy_o = 1. SCL rises and stops are ignored.
  - DATA, SCL rising edge, bit_cnt 0..7: shift SDA into shreg (MSB first); bit_cnt++.
  - DATA, SCL rising edge, bit_cnt == 8: push BYTE{data = shreg, ack = SDA}; bit_cnt = 0.
  - DATA, start condition: push RSTART; bit_cnt = 0. evt_err = 1 if bit_cnt != 0.
  - DATA, stop condition: push STOP; go to IDLE; bus_busy_o = 0. evt_err = 1 if bit_cnt != 0.
- Latency, with FIFO empty: evt_valid_o rises 2 + FILTER_LEN + 2 cycles after the raw pin change that completes the event. That is 7 cycles at the default.
- FIFO:
  - Head is shown on the evt_* outputs and is registered.
  - Pop when evt_valid_o && evt_ready_i.
  - Simultaneous push and pop while full: the push is accepted and nothing is dropped.
  - Push while full without a pop: the event is dropped and overflow_o = 1 from the next cycle.
  - clr_ovf_i clears overflow_o. If clr_ovf_i and a drop occur in the same cycle, set wins.
- Pointers use log2(FIFO_DEPTH)+1 bits; wrap is natural modulo.
- evt_* outputs are stable while evt_valid_o is high and evt_ready_i is low.

Decomposition:
- Package i2c_decoder_pkg holds:
  - typedef enum logic [1:0] i2c_evt_type_t {START, RSTART, STOP, BYTE}.
  - typedef struct packed i2c_evt_t {type, data[7:0], ack, err} (12 bits).
- One sub-module, i2c_evt_fifo: synchronous FIFO of i2c_evt_t with parameter FIFO_DEPTH, push/pop/full/empty.
- Synchronizer, filter and FSM stay in the top module.

Test Plan:
- Write 0xA4 with ACK, evt_ready_i=1: START, 8 bits 1010_0100, ACK=0, STOP -> events START; BYTE{data=0xA4, ack=0, err=0}; STOP. bus_busy_o is 1 between START and STOP. First evt_valid_o appears 7 cycles after the SDA fall.
- Repeated start: START, byte 0x50/ACK, START, byte 0x51/NACK, STOP -> START, BYTE 0x50 ack=0, RSTART err=0, BYTE 0x51 ack=1, STOP.
- Abort: START, 3 bits, then STOP -> START; STOP with err=1; no BYTE event; FSM returns to IDLE.
- Glitch: 2-cycle low pulse on SDA while SCL is high and the bus is idle (FILTER_LEN=3) -> no event; bus_busy_o stays 0.
- Overflow: evt_ready_i=0, FIFO_DEPTH=4, generate 6 events -> first 4 retained in order; overflow_o=1. Pulsing clr_ovf_i clears it. Then assert ready -> the 4 events drain in order.
- Reset mid-byte: rst_i low for 1 cycle after 5 bits -> all outputs 0. Then a new START/byte 0x3C/STOP decodes cleanly with err=0.
